// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns a raw two-channel quadrature input into detent-sized
// step pulses plus a direction level, and flags illegal phase jumps.
// Pipeline: 2-flop synchroniser -> per-channel debounce -> phase compare ->
// signed quarter-step accumulator -> registered step/up_down/err outputs.
module quad_step_decoder #(
   parameter int DEB_CYCLES = 16,
   parameter int DETENT     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic a_in,
   input  logic b_in,
   output logic step,
   output logic up_down,
   output logic err
);

   localparam int CW = $clog2(DEB_CYCLES);
   // Four signed bits comfortably hold the largest range, -3..+3.
   localparam int AW = 4;
   localparam logic [CW-1:0]        DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic signed [AW-1:0] ACC_MAX  = AW'(DETENT - 1);
   localparam logic signed [AW-1:0] ACC_MIN  = -ACC_MAX;
   localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);

   // Synchroniser stages; a_s_q / b_s_q are the only copies used downstream.
   logic a_meta_q, a_meta_d, a_s_q, a_s_d;
   logic b_meta_q, b_meta_d, b_s_q, b_s_d;

   // Debounced levels and their stability counters.
   logic          a_deb_q, a_deb_d, b_deb_q, b_deb_d;
   logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

   // Phase tracking, accumulator and registered outputs.
   logic [1:0]          prev_q, prev_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic                step_q, step_d;
   logic                up_down_q, up_down_d;
   logic                err_q, err_d;

   logic [1:0] cur_phase;
   logic [1:0] delta;

   // Position of a phase along the up sequence 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] phase_pos(input logic [1:0] ph);
      case (ph)
         2'b00:   phase_pos = 2'd0;
         2'b10:   phase_pos = 2'd1;
         2'b11:   phase_pos = 2'd2;
         default: phase_pos = 2'd3;
      endcase
   endfunction

   // Shift both raw pins through two flops each.
   always_comb begin
      a_meta_d = a_in;
      a_s_d    = a_meta_q;
      b_meta_d = b_in;
      b_s_d    = b_meta_q;
   end

   // Channel A debounce: adopt the synchronised level only after it has
   // differed from the debounced level for DEB_CYCLES consecutive cycles.
   always_comb begin
      a_deb_d = a_deb_q;
      a_cnt_d = a_cnt_q;
      if (a_s_q == a_deb_q) begin
         a_cnt_d = '0;
      end else if (a_cnt_q == DEB_LAST) begin
         a_deb_d = a_s_q;
         a_cnt_d = '0;
      end else begin
         a_cnt_d = a_cnt_q + CW'(1);
      end
   end

   // Channel B debounce, identical to channel A.
   always_comb begin
      b_deb_d = b_deb_q;
      b_cnt_d = b_cnt_q;
      if (b_s_q == b_deb_q) begin
         b_cnt_d = '0;
      end else if (b_cnt_q == DEB_LAST) begin
         b_deb_d = b_s_q;
         b_cnt_d = '0;
      end else begin
         b_cnt_d = b_cnt_q + CW'(1);
      end
   end

   assign cur_phase = {a_deb_q, b_deb_q};
   // delta: 0 = no change, 1 = up quarter-step, 3 = down, 2 = both bits moved.
   assign delta     = phase_pos(cur_phase) - phase_pos(prev_q);

   // Decode the phase change and accumulate quarter-steps into detents.
   // prev always tracks the current phase so a disabled period never leaves
   // a stale phase behind; en=0 only freezes the accumulator and step.
   always_comb begin
      prev_d    = cur_phase;
      acc_d     = acc_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
      up_down_d = up_down_q;
      case (delta)
         2'd1: begin
            if (en) begin
               if (acc_q == ACC_MAX) begin
                  acc_d     = '0;
                  step_d    = 1'b1;
                  up_down_d = 1'b1;
               end else begin
                  acc_d = acc_q + ACC_ONE;
               end
            end
         end
         2'd3: begin
            if (en) begin
               if (acc_q == ACC_MIN) begin
                  acc_d     = '0;
                  step_d    = 1'b1;
                  up_down_d = 1'b0;
               end else begin
                  acc_d = acc_q - ACC_ONE;
               end
            end
         end
         2'd2: begin
            err_d = 1'b1;
            if (en) begin
               acc_d = '0;
            end
         end
         default: begin
         end
      endcase
   end

   // All state registers; reset clears partial progress, direction defaults up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_meta_q  <= 1'b0;
         a_s_q     <= 1'b0;
         b_meta_q  <= 1'b0;
         b_s_q     <= 1'b0;
         a_deb_q   <= 1'b0;
         b_deb_q   <= 1'b0;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         prev_q    <= 2'b00;
         acc_q     <= '0;
         step_q    <= 1'b0;
         up_down_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         a_meta_q  <= a_meta_d;
         a_s_q     <= a_s_d;
         b_meta_q  <= b_meta_d;
         b_s_q     <= b_s_d;
         a_deb_q   <= a_deb_d;
         b_deb_q   <= b_deb_d;
         a_cnt_q   <= a_cnt_d;
         b_cnt_q   <= b_cnt_d;
         prev_q    <= prev_d;
         acc_q     <= acc_d;
         step_q    <= step_d;
         up_down_q <= up_down_d;
         err_q     <= err_d;
      end
   end

   assign step    = step_q;
   assign up_down = up_down_q;
   assign err     = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with DEB_CYCLES=4, DETENT=4.
// Every pin level is held long enough (10 cycles) for the 7-edge latency.
module tb_quad_step_decoder;

   logic clk = 1'b0;
   logic reset;
   logic en;
   logic a_in;
   logic b_in;
   logic step;
   logic up_down;
   logic err;

   int checks = 0;
   int passed = 0;
   int step_cnt;
   int err_cnt;
   int dbl_cnt;
   logic prev_step;
   logic prev_err;

   quad_step_decoder #(.DEB_CYCLES(4), .DETENT(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .a_in    (a_in),
      .b_in    (b_in),
      .step    (step),
      .up_down (up_down),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Drive pins, then sample outputs on n falling edges.
   task automatic hold_ab(input logic a, input logic b, input int n);
      a_in = a;
      b_in = b;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (step) step_cnt++;
         if (err) err_cnt++;
         if ((step && prev_step) || (err && prev_err)) dbl_cnt++;
         prev_step = step;
         prev_err  = err;
      end
   endtask

   task automatic clr_counts();
      step_cnt  = 0;
      err_cnt   = 0;
      dbl_cnt   = 0;
      prev_step = 1'b0;
      prev_err  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b1;
      a_in  = 1'b0;
      b_in  = 1'b0;
      clr_counts();
      repeat (3) @(negedge clk);
      checks++; if (step !== 1'b0) $display("FAIL rst_step: got %b want 0", step); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
      checks++; if (up_down !== 1'b1) $display("FAIL rst_up_down: got %b want 1", up_down); else passed++;
      checks++; if (dut.acc_q !== 4'sd0) $display("FAIL rst_acc: got %0d want 0", dut.acc_q); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_up();
      for (int s = 0; s < 2; s++) begin
         clr_counts();
         hold_ab(1'b1, 1'b0, 10);
         hold_ab(1'b1, 1'b1, 10);
         hold_ab(1'b0, 1'b1, 10);
         checks++; if (step_cnt !== 0) $display("FAIL up_partial%0d: got %0d steps want 0", s, step_cnt); else passed++;
         hold_ab(1'b0, 1'b0, 10);
         checks++; if (step_cnt !== 1) $display("FAIL up_steps%0d: got %0d want 1", s, step_cnt); else passed++;
         checks++; if (up_down !== 1'b1) $display("FAIL up_dir%0d: got %b want 1", s, up_down); else passed++;
         checks++; if (err_cnt !== 0 || dbl_cnt !== 0) $display("FAIL up_err%0d: err=%0d dbl=%0d want 0 0", s, err_cnt, dbl_cnt); else passed++;
      end
   endtask

   task automatic test_down();
      clr_counts();
      hold_ab(1'b0, 1'b1, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b1, 1'b0, 10);
      checks++; if (step_cnt !== 0) $display("FAIL down_partial: got %0d steps want 0", step_cnt); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (step_cnt !== 1 || dbl_cnt !== 0) $display("FAIL down_steps: got %0d dbl=%0d want 1 0", step_cnt, dbl_cnt); else passed++;
      checks++; if (up_down !== 1'b0) $display("FAIL down_dir: got %b want 0", up_down); else passed++;
      hold_ab(1'b0, 1'b0, 20);
      checks++; if (up_down !== 1'b0) $display("FAIL down_dir_hold: got %b want 0", up_down); else passed++;
   endtask

   task automatic test_glitch();
      clr_counts();
      hold_ab(1'b1, 1'b0, 3);
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (dut.a_deb_q !== 1'b0) $display("FAIL glitch3_deb: got %b want 0", dut.a_deb_q); else passed++;
      checks++; if (step_cnt !== 0 || err_cnt !== 0) $display("FAIL glitch3_out: step=%0d err=%0d want 0 0", step_cnt, err_cnt); else passed++;
      // Four-cycle pulse: debounced A rises on edge 6, acc becomes 1 on edge 7.
      hold_ab(1'b1, 1'b0, 4);
      hold_ab(1'b0, 1'b0, 3);
      checks++; if (dut.a_deb_q !== 1'b1) $display("FAIL glitch4_deb: got %b want 1", dut.a_deb_q); else passed++;
      checks++; if (dut.acc_q !== 4'sd1) $display("FAIL glitch4_acc: got %0d want 1", dut.acc_q); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (step_cnt !== 0 || err_cnt !== 0) $display("FAIL glitch4_out: step=%0d err=%0d want 0 0", step_cnt, err_cnt); else passed++;
      checks++; if (dut.acc_q !== 4'sd0) $display("FAIL glitch4_unwind: got %0d want 0", dut.acc_q); else passed++;
   endtask

   task automatic test_illegal();
      clr_counts();
      hold_ab(1'b1, 1'b1, 10);
      checks++; if (err_cnt !== 1 || dbl_cnt !== 0) $display("FAIL ill_err: got %0d dbl=%0d want 1 0", err_cnt, dbl_cnt); else passed++;
      checks++; if (step_cnt !== 0) $display("FAIL ill_step: got %0d want 0", step_cnt); else passed++;
      checks++; if (up_down !== 1'b0) $display("FAIL ill_dir: got %b want 0", up_down); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      checks++; if (dut.acc_q !== 4'sd2) $display("FAIL ill_acc_pre: got %0d want 2", dut.acc_q); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (dut.acc_q !== 4'sd0) $display("FAIL ill_acc_clr: got %0d want 0", dut.acc_q); else passed++;
      checks++; if (err_cnt !== 3 || step_cnt !== 0) $display("FAIL ill_totals: err=%0d step=%0d want 3 0", err_cnt, step_cnt); else passed++;
   endtask

   task automatic test_enable();
      clr_counts();
      en = 1'b0;
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b0, 1'b1, 10);
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (step_cnt !== 0) $display("FAIL en0_step: got %0d want 0", step_cnt); else passed++;
      checks++; if (dut.acc_q !== 4'sd0) $display("FAIL en0_acc: got %0d want 0", dut.acc_q); else passed++;
      en = 1'b1;
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b0, 1'b1, 10);
      checks++; if (step_cnt !== 0) $display("FAIL en1_partial: got %0d want 0", step_cnt); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (step_cnt !== 1 || up_down !== 1'b1) $display("FAIL en1_step: got %0d dir=%b want 1 1", step_cnt, up_down); else passed++;
   endtask

   task automatic test_async_reset();
      logic found;
      clr_counts();
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b0, 1'b1, 10);
      checks++; if (dut.acc_q !== 4'sd3 || step_cnt !== 0) $display("FAIL ar_acc3: got %0d steps=%0d want 3 0", dut.acc_q, step_cnt); else passed++;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (dut.acc_q !== 4'sd0 || step !== 1'b0 || err !== 1'b0) $display("FAIL ar_clear: acc=%0d step=%b err=%b want 0 0 0", dut.acc_q, step, err); else passed++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      // Pins still at 01: B rises from reset as a down quarter-step (acc=-1).
      clr_counts();
      hold_ab(1'b0, 1'b1, 10);
      hold_ab(1'b0, 1'b0, 10);
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b0, 1'b1, 10);
      checks++; if (step_cnt !== 0) $display("FAIL ar_partial: got %0d want 0", step_cnt); else passed++;
      hold_ab(1'b0, 1'b0, 10);
      checks++; if (step_cnt !== 1) $display("FAIL ar_step: got %0d want 1", step_cnt); else passed++;
      // Down detent, then reset while the step pulse is high.
      hold_ab(1'b0, 1'b1, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b1, 1'b0, 10);
      a_in  = 1'b0;
      b_in  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #1;
         if (step) found = 1'b1;
      end
      checks++; if (!found || up_down !== 1'b0) $display("FAIL ar_pulse: found=%b dir=%b want 1 0", found, up_down); else passed++;
      #1 reset = 1'b1;
      #1;
      checks++; if (step !== 1'b0 || up_down !== 1'b1) $display("FAIL ar_pulse_clr: step=%b dir=%b want 0 1", step, up_down); else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_glitch();
      test_illegal();
      test_enable();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
